// File: rtl/bank_ring_buffer.sv
// bank_ring_buffer: multi-bank frame buffer between the windowing front end
// and the FFT core. The writer fills banks in ring order. Each completed bank
// is handed to the reader. The reader addresses the oldest complete bank with
// registered reads and releases it back to the writer when it is finished.
// Storage is a single simple dual-port RAM indexed by {bank, address}. This
// lets no_banks be any value >= 2, including values that are not a power of two.
module bank_ring_buffer #(
  parameter int no_banks      = 8,
  parameter int word_width    = 16,
  parameter int address_width = 5,
  localparam int BW = (no_banks > 1) ? $clog2(no_banks) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [word_width-1:0]    wr_data,
  output logic                     rd_bank_valid,
  output logic [BW-1:0]            rd_bank,
  input  logic                     rd_en,
  input  logic [address_width-1:0] rd_address,
  output logic [word_width-1:0]    rd_data,
  output logic                     rd_data_valid,
  input  logic                     rd_release,
  output logic [BW:0]              full_count
);

  localparam int DEPTH = 2 ** address_width;
  localparam int MW    = BW + address_width;
  localparam logic [BW:0]              FULL_C      = (BW+1)'(no_banks);
  localparam logic [BW:0]              EMPTY_C     = {(BW+1){1'b0}};
  localparam logic [BW-1:0]            LAST_BANK_C = BW'(no_banks - 1);
  localparam logic [BW-1:0]            ZERO_BANK_C = {BW{1'b0}};
  localparam logic [address_width-1:0] LAST_ADDR_C = {address_width{1'b1}};
  localparam logic [address_width-1:0] ZERO_ADDR_C = {address_width{1'b0}};

  // Bank storage. It is never reset, so frame contents survive a reset.
  logic [word_width-1:0] mem_r [0:no_banks*DEPTH-1];

  logic [BW-1:0]            wb_r;
  logic [address_width-1:0] wa_r;
  logic [BW-1:0]            rb_r;
  logic [BW:0]              full_count_r;
  logic [word_width-1:0]    rd_data_r;
  logic                     rd_data_valid_r;

  logic                     wr_ready_s;
  logic                     rd_bank_valid_s;
  logic                     wr_accept_s;
  logic                     bank_done_s;
  logic                     rd_accept_s;
  logic                     rel_accept_s;
  logic [BW-1:0]            wb_next_s;
  logic [BW-1:0]            rb_next_s;
  logic [MW-1:0]            wr_index_s;
  logic [MW-1:0]            rd_index_s;

  // Handshake qualification and ring-pointer successors from registered state.
  always_comb begin
    wr_ready_s      = (full_count_r != FULL_C);
    rd_bank_valid_s = (full_count_r != EMPTY_C);
    wr_accept_s     = wr_valid && wr_ready_s;
    bank_done_s     = wr_accept_s && (wa_r == LAST_ADDR_C);
    rd_accept_s     = rd_en && rd_bank_valid_s;
    rel_accept_s    = rd_release && rd_bank_valid_s;
    wr_index_s      = {wb_r, wa_r};
    rd_index_s      = {rb_r, rd_address};
    if (wb_r == LAST_BANK_C) begin
      wb_next_s = ZERO_BANK_C;
    end else begin
      wb_next_s = wb_r + 1'b1;
    end
    if (rb_r == LAST_BANK_C) begin
      rb_next_s = ZERO_BANK_C;
    end else begin
      rb_next_s = rb_r + 1'b1;
    end
  end

  // Writer/reader pointers and the count of complete, unreleased banks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_r         <= ZERO_BANK_C;
      wa_r         <= ZERO_ADDR_C;
      rb_r         <= ZERO_BANK_C;
      full_count_r <= EMPTY_C;
    end else begin
      if (wr_accept_s) begin
        wa_r <= wa_r + 1'b1;
        if (bank_done_s) begin
          wb_r <= wb_next_s;
        end
      end
      if (rel_accept_s) begin
        rb_r <= rb_next_s;
      end
      case ({bank_done_s, rel_accept_s})
        2'b10:   full_count_r <= full_count_r + 1'b1;
        2'b01:   full_count_r <= full_count_r - 1'b1;
        default: full_count_r <= full_count_r;
      endcase
    end
  end

  // RAM write port. The bank being filled is never readable, so no bypass exists.
  always_ff @(posedge clk) begin
    if (wr_accept_s) begin
      mem_r[wr_index_s] <= wr_data;
    end
  end

  // RAM read port with one-cycle registered data. Ignored reads hold rd_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_r       <= {word_width{1'b0}};
      rd_data_valid_r <= 1'b0;
    end else if (rd_accept_s) begin
      rd_data_r       <= mem_r[rd_index_s];
      rd_data_valid_r <= 1'b1;
    end else begin
      rd_data_valid_r <= 1'b0;
    end
  end

  assign wr_ready      = wr_ready_s;
  assign rd_bank_valid = rd_bank_valid_s;
  assign rd_bank       = rb_r;
  assign full_count    = full_count_r;
  assign rd_data       = rd_data_r;
  assign rd_data_valid = rd_data_valid_r;

endmodule

// File: tb/tb_bank_ring_buffer.sv
// Testbench for bank_ring_buffer. It drives an 8-bank instance and a 3-bank
// instance. The reference model numbers every completed frame serially.
// The oldest unreleased frame is the readable one, so the expected bank index
// is simply (frames released) mod no_banks.
module tb_bank_ring_buffer;

  logic clk;
  logic rst_n;

  logic        wv0, re0, rel0, wr0, rbv0, rdv0;
  logic [15:0] wd0, rdat0;
  logic [4:0]  ra0;
  logic [2:0]  rb0;
  logic [3:0]  fc0;

  logic        wv1, re1, rel1, wr1, rbv1, rdv1;
  logic [15:0] wd1, rdat1;
  logic [4:0]  ra1;
  logic [1:0]  rb1;
  logic [2:0]  fc1;

  bank_ring_buffer #(.no_banks(8), .word_width(16), .address_width(5)) dut8 (
    .clk(clk), .rst_n(rst_n), .wr_valid(wv0), .wr_ready(wr0), .wr_data(wd0),
    .rd_bank_valid(rbv0), .rd_bank(rb0), .rd_en(re0), .rd_address(ra0),
    .rd_data(rdat0), .rd_data_valid(rdv0), .rd_release(rel0), .full_count(fc0)
  );

  bank_ring_buffer #(.no_banks(3), .word_width(16), .address_width(5)) dut3 (
    .clk(clk), .rst_n(rst_n), .wr_valid(wv1), .wr_ready(wr1), .wr_data(wd1),
    .rd_bank_valid(rbv1), .rd_bank(rb1), .rd_en(re1), .rd_address(ra1),
    .rd_data(rdat1), .rd_data_valid(rdv1), .rd_release(rel1), .full_count(fc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;
  int nb [2];
  int done_c [2];
  int rel_c [2];
  int wlen [2];
  logic [15:0] hist [2][256][32];
  logic [15:0] m_rdata [2];
  logic        m_rdv [2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      done_c[d]  = 0;
      rel_c[d]   = 0;
      wlen[d]    = 0;
      m_rdata[d] = 16'd0;
      m_rdv[d]   = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wv0 = 1'b0; re0 = 1'b0; rel0 = 1'b0; wd0 = 16'd0; ra0 = 5'd0;
    wv1 = 1'b0; re1 = 1'b0; rel1 = 1'b0; wd1 = 16'd0; ra1 = 5'd0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // One clock of stimulus on DUT d. The model is updated from the pre-edge state.
  task automatic step(input int d, input logic wv, input logic [15:0] wd,
                      input logic re, input logic [4:0] ra, input logic rel);
    int cnt;
    bit wacc, racc, relacc;
    if (d == 0) begin
      wv0 = wv; wd0 = wd; re0 = re; ra0 = ra; rel0 = rel;
      wv1 = 1'b0; re1 = 1'b0; rel1 = 1'b0;
    end else begin
      wv1 = wv; wd1 = wd; re1 = re; ra1 = ra; rel1 = rel;
      wv0 = 1'b0; re0 = 1'b0; rel0 = 1'b0;
    end
    cnt    = done_c[d] - rel_c[d];
    wacc   = wv && (cnt != nb[d]);
    racc   = re && (cnt != 0);
    relacc = rel && (cnt != 0);
    m_rdv[1-d] = 1'b0;
    m_rdv[d]   = racc;
    if (racc) m_rdata[d] = hist[d][rel_c[d] % 256][ra];
    @(posedge clk);
    #1;
    if (relacc) rel_c[d]++;
    if (wacc) begin
      hist[d][done_c[d] % 256][wlen[d]] = wd;
      wlen[d]++;
      if (wlen[d] == 32) begin
        wlen[d] = 0;
        done_c[d]++;
      end
    end
  endtask

  task automatic write_words(input int d, input int n);
    for (int i = 0; i < n; i++) step(d, 1'b1, 16'($urandom), 1'b0, 5'd0, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (wr0 !== 1'b1) begin n_err++; $display("FAIL reset_wr_ready: got %b want 1", wr0); end
    n_vec++; if (rbv0 !== 1'b0) begin n_err++; $display("FAIL reset_rd_bank_valid: got %b want 0", rbv0); end
    n_vec++; if (fc0 !== 4'd0) begin n_err++; $display("FAIL reset_full_count: got %0d want 0", fc0); end
    n_vec++; if (rdat0 !== 16'd0) begin n_err++; $display("FAIL reset_rd_data: got %h want 0", rdat0); end
    n_vec++; if (rdv0 !== 1'b0) begin n_err++; $display("FAIL reset_rd_data_valid: got %b want 0", rdv0); end
    n_vec++; if (rb0 !== 3'd0) begin n_err++; $display("FAIL reset_rd_bank: got %0d want 0", rb0); end
    n_vec++; if (fc1 !== 3'd0 || wr1 !== 1'b1) begin n_err++; $display("FAIL reset_dut3: fc=%0d rdy=%b want 0/1", fc1, wr1); end
  endtask

  task automatic test_stream_read();
    do_reset();
    for (int i = 0; i < 32; i++) begin
      step(0, 1'b1, 16'(i), 1'b0, 5'd0, 1'b0);
      if (i == 30) begin
        n_vec++;
        if (rbv0 !== 1'b0) begin n_err++; $display("FAIL stream_valid_early: got %b want 0", rbv0); end
      end
    end
    n_vec++;
    if (rbv0 !== 1'b1 || rb0 !== 3'd0) begin
      n_err++; $display("FAIL stream_bank_ready: valid=%b bank=%0d want 1/0", rbv0, rb0);
    end
    for (int a = 0; a < 32; a++) begin
      step(0, 1'b0, 16'd0, 1'b1, 5'(a), 1'b0);
      n_vec++;
      if (rdv0 !== 1'b1 || rdat0 !== 16'(a) || rdat0 !== m_rdata[0]) begin
        n_err++; $display("FAIL stream_read addr %0d: got %h v=%b want %h v=1", a, rdat0, rdv0, 16'(a));
      end
    end
    step(0, 1'b0, 16'd0, 1'b0, 5'd0, 1'b0);
    n_vec++;
    if (rdv0 !== 1'b0 || rdat0 !== 16'd31) begin
      n_err++; $display("FAIL stream_idle_hold: got %h v=%b want 001f v=0", rdat0, rdv0);
    end
  endtask

  task automatic test_fill_stall();
    logic [15:0] s257;
    do_reset();
    write_words(0, 256);
    n_vec++;
    if (fc0 !== 4'd8 || wr0 !== 1'b0) begin
      n_err++; $display("FAIL full_state: fc=%0d rdy=%b want 8/0", fc0, wr0);
    end
    s257 = 16'($urandom);
    step(0, 1'b1, s257, 1'b0, 5'd0, 1'b0);
    n_vec++;
    if (fc0 !== 4'd8 || wr0 !== 1'b0) begin
      n_err++; $display("FAIL full_stall: fc=%0d rdy=%b want 8/0", fc0, wr0);
    end
    step(0, 1'b1, s257, 1'b0, 5'd0, 1'b1);
    n_vec++;
    if (fc0 !== 4'd7 || rb0 !== 3'd1 || wr0 !== 1'b1) begin
      n_err++; $display("FAIL full_release: fc=%0d bank=%0d rdy=%b want 7/1/1", fc0, rb0, wr0);
    end
    step(0, 1'b1, s257, 1'b0, 5'd0, 1'b0);
    write_words(0, 31);
    for (int k = 0; k < 7; k++) step(0, 1'b0, 16'd0, 1'b0, 5'd0, 1'b1);
    n_vec++;
    if (fc0 !== 4'd1 || rb0 !== 3'd0) begin
      n_err++; $display("FAIL full_wrap: fc=%0d bank=%0d want 1/0", fc0, rb0);
    end
    step(0, 1'b0, 16'd0, 1'b1, 5'd0, 1'b0);
    n_vec++;
    if (rdat0 !== s257 || rdv0 !== 1'b1) begin
      n_err++; $display("FAIL full_sample257: got %h v=%b want %h v=1", rdat0, rdv0, s257);
    end
    for (int k = 0; k < 4; k++) begin
      step(0, 1'b0, 16'd0, 1'b1, 5'($urandom), 1'b0);
      n_vec++;
      if (rdat0 !== m_rdata[0]) begin n_err++; $display("FAIL full_bank0_read: got %h want %h", rdat0, m_rdata[0]); end
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    write_words(0, 64);
    step(0, 1'b0, 16'd0, 1'b0, 5'd0, 1'b1);
    write_words(0, 31);
    n_vec++;
    if (fc0 !== 4'd1 || rb0 !== 3'd1) begin
      n_err++; $display("FAIL simul_setup: fc=%0d bank=%0d want 1/1", fc0, rb0);
    end
    step(0, 1'b1, 16'($urandom), 1'b0, 5'd0, 1'b1);
    n_vec++;
    if (fc0 !== 4'd1 || rb0 !== 3'd2) begin
      n_err++; $display("FAIL simul_complete_release: fc=%0d bank=%0d want 1/2", fc0, rb0);
    end
    for (int k = 0; k < 4; k++) begin
      step(0, 1'b0, 16'd0, 1'b1, 5'($urandom), 1'b0);
      n_vec++;
      if (rdat0 !== m_rdata[0] || rdv0 !== 1'b1) begin
        n_err++; $display("FAIL simul_bank2_read: got %h want %h", rdat0, m_rdata[0]);
      end
    end
  endtask

  task automatic test_wrap3();
    do_reset();
    write_words(1, 96);
    n_vec++;
    if (fc1 !== 3'd3 || wr1 !== 1'b0) begin
      n_err++; $display("FAIL wrap3_full: fc=%0d rdy=%b want 3/0", fc1, wr1);
    end
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if (rb1 !== 2'(k % 3) || rbv1 !== 1'b1) begin
        n_err++; $display("FAIL wrap3_bank frame %0d: got %0d want %0d", k, rb1, k % 3);
      end
      for (int a = 0; a < 32; a++) begin
        step(1, 1'b0, 16'd0, 1'b1, 5'(a), 1'b0);
        n_vec++;
        if (rdat1 !== m_rdata[1] || rdv1 !== 1'b1) begin
          n_err++; $display("FAIL wrap3_data frame %0d addr %0d: got %h want %h", k, a, rdat1, m_rdata[1]);
        end
      end
      step(1, 1'b0, 16'd0, 1'b0, 5'd0, 1'b1);
      if (k == 0) write_words(1, 32);
    end
    n_vec++;
    if (fc1 !== 3'd0 || rbv1 !== 1'b0 || rb1 !== 2'd1) begin
      n_err++; $display("FAIL wrap3_drained: fc=%0d v=%b bank=%0d want 0/0/1", fc1, rbv1, rb1);
    end
  endtask

  task automatic test_ignored_and_reset();
    do_reset();
    step(0, 1'b0, 16'd0, 1'b1, 5'($urandom), 1'b1);
    n_vec++;
    if (rdv0 !== 1'b0 || rdat0 !== 16'd0 || fc0 !== 4'd0 || rb0 !== 3'd0) begin
      n_err++; $display("FAIL ignored_requests: v=%b d=%h fc=%0d bank=%0d want 0/0/0/0", rdv0, rdat0, fc0, rb0);
    end
    write_words(0, 48);
    step(0, 1'b1, 16'($urandom), 1'b1, 5'($urandom), 1'b0);
    n_vec++;
    if (fc0 !== 4'd1 || rdv0 !== 1'b1 || rdat0 !== m_rdata[0]) begin
      n_err++; $display("FAIL pre_reset: fc=%0d v=%b d=%h want 1/1/%h", fc0, rdv0, rdat0, m_rdata[0]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (fc0 !== 4'd0 || wr0 !== 1'b1 || rbv0 !== 1'b0 || rb0 !== 3'd0 || rdat0 !== 16'd0 || rdv0 !== 1'b0) begin
      n_err++; $display("FAIL async_reset: fc=%0d rdy=%b v=%b bank=%0d d=%h dv=%b want 0/1/0/0/0/0",
                        fc0, wr0, rbv0, rb0, rdat0, rdv0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    write_words(0, 32);
    n_vec++;
    if (fc0 !== 4'd1 || rb0 !== 3'd0) begin
      n_err++; $display("FAIL post_reset_frame: fc=%0d bank=%0d want 1/0", fc0, rb0);
    end
    for (int a = 0; a < 32; a += 31) begin
      step(0, 1'b0, 16'd0, 1'b1, 5'(a), 1'b0);
      n_vec++;
      if (rdat0 !== m_rdata[0]) begin n_err++; $display("FAIL post_reset_read addr %0d: got %h want %h", a, rdat0, m_rdata[0]); end
    end
  endtask

  task automatic test_random(input int d, input int cycles);
    int cnt;
    logic [31:0] o_fc, o_rb;
    logic o_wr, o_rbv, o_rdv;
    logic [15:0] o_rd;
    logic rel;
    do_reset();
    for (int c = 0; c < cycles; c++) begin
      if (c < cycles / 2) rel = ($urandom_range(0, 63) == 0);
      else rel = ($urandom_range(0, 7) == 0);
      step(d, 1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom_range(0, 1)), 5'($urandom), rel);
      cnt = done_c[d] - rel_c[d];
      if (d == 0) begin
        o_fc = {28'd0, fc0}; o_rb = {29'd0, rb0}; o_wr = wr0; o_rbv = rbv0; o_rdv = rdv0; o_rd = rdat0;
      end else begin
        o_fc = {29'd0, fc1}; o_rb = {30'd0, rb1}; o_wr = wr1; o_rbv = rbv1; o_rdv = rdv1; o_rd = rdat1;
      end
      n_vec++;
      if (o_fc !== 32'(cnt) || o_rb !== 32'(rel_c[d] % nb[d]) || o_wr !== 1'(cnt != nb[d]) ||
          o_rbv !== 1'(cnt != 0) || o_rdv !== m_rdv[d] || o_rd !== m_rdata[d]) begin
        n_err++;
        $display("FAIL random dut%0d cyc %0d: fc=%0d bank=%0d rdy=%b v=%b dv=%b d=%h want %0d/%0d/%b/%b/%b/%h",
                 d, c, o_fc, o_rb, o_wr, o_rbv, o_rdv, o_rd, cnt, rel_c[d] % nb[d], 1'(cnt != nb[d]),
                 1'(cnt != 0), m_rdv[d], m_rdata[d]);
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    nb[0] = 8;
    nb[1] = 3;
    rst_n = 1'b0;
    test_reset();
    test_stream_read();
    test_fill_stall();
    test_simultaneous();
    test_wrap3();
    test_ignored_and_reset();
    test_random(0, 1500);
    test_random(1, 1500);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/bank_ring_buffer.md
Name: bank_ring_buffer

Overview:
- Parametrised multi-bank frame buffer and successor to the plain banked RAM.
- Writer streams samples with a valid/ready handshake. Each bank fills in turn, and a bank is handed to the reader when it completes.
- Reader randomly addresses the oldest complete bank with registered 1-cycle reads, then releases it back to the writer.
- Sits between the sample/windowing front end and the FFT core of the spectrogram pipeline. It ping-pongs (or multi-buffers) frames.

Parameters:
- no_banks, 8, number of banks; must be >= 2 and need not be a power of two.
- word_width, 16, bits per sample.
- address_width, 5, bits of address per bank; bank depth = 2**address_width.
- BW (localparam) = clog2(no_banks), minimum 1.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- wr_valid  in  1  writer presents wr_data.
- wr_ready  out  1  buffer can accept a sample.
- wr_data  in  word_width  sample to store.
- rd_bank_valid  out  1  at least one complete bank is readable.
- rd_bank  out  BW  index of the oldest complete bank.
- rd_en  in  1  read request.
- rd_address  in  address_width  word address within rd_bank.
- rd_data  out  word_width  registered read data.
- rd_data_valid  out  1  rd_data holds the result of the previous cycle's accepted read.
- rd_release  in  1  reader has finished with rd_bank.
- full_count  out  BW+1  number of complete, unreleased banks.

Behaviour:
- Reset (async assert, sync release):
  - wr bank pointer wb = 0, wr address wa = 0, rd bank pointer rb = 0.
  - full_count = 0, rd_data = 0, rd_data_valid = 0, rd_bank_valid = 0, rd_bank = 0, wr_ready = 1.
  - Memory contents are not cleared.
- Reset mid-frame discards the partial frame and all complete banks.
- wr_ready = (full_count != no_banks). It is combinational from registered state and does not depend on wr_valid.
- Write accept = wr_valid && wr_ready:
  - mem[wb][wa] <= wr_data; wa <= wa+1.
  - When wa == 2**address_width-1 on accept: wa <= 0, wb <= (wb == no_banks-1) ? 0 : wb+1, and the bank is marked complete (count increment).
- A write with wr_valid=1 and wr_ready=0 is a stall. Data is not written and the writer must hold its data.
- rd_bank_valid = (full_count != 0); rd_bank = rb.
- Read accept = rd_en && rd_bank_valid:
  - Next cycle, rd_data = mem[rb][rd_address] and rd_data_valid = 1.
- If rd_en is asserted while rd_bank_valid = 0, it is ignored. Next cycle rd_data_valid = 0 and rd_data holds its last value.
- rd_data_valid is 0 on any cycle after no read was accepted.
- Release accept = rd_release && rd_bank_valid: rb <= (rb == no_banks-1) ? 0 : rb+1 (count decrement). A release while rd_bank_valid = 0 is ignored.
- full_count next value:
  - +1 on bank completion only.
  - -1 on release only.
  - Unchanged when both happen in the same cycle.
- A read and a release in the same cycle: the read uses the pre-release rb, and its data is returned next cycle.
- Writer and reader never alias. While full_count < no_banks, wb is not a complete bank. When full_count == no_banks, wb == rb but writes are stalled.
- A simultaneous write to a bank and read of a different bank is always legal. Memory is simple dual-port: one write port, one read port.
- Bank storage is inferred as a single RAM addressed {bank, address}. The generic bank mux/decode replaces per-bank case statements, so any no_banks works.
- Reads from the bank currently being filled are impossible by construction, so no read-during-write forwarding is needed.

Test Plan:
1. Reset then idle, defaults (no_banks=8, address_width=5, word_width=16) -> wr_ready=1, rd_bank_valid=0, full_count=0, rd_data=0, rd_data_valid=0.
2. Stream 32 samples 0..31 with wr_valid held high, then read addresses 0..31 back-to-back -> rd_bank_valid rises the cycle after the 32nd accept with rd_bank=0. rd_data equals the address, one cycle after each rd_en, with rd_data_valid=1.
3. Write 8*32 samples with no release -> full_count=8, wr_ready=0. Sample 257 is held off. Assert rd_release once -> full_count=7, rd_bank=1, wr_ready=1, and sample 257 lands in bank 0, address 0.
4. On the same cycle the writer completes bank 2 and the reader releases bank 1 -> full_count is unchanged and rd_bank advances to 2.
5. no_banks=3: fill and release 4 frames with distinct data patterns -> wb/rb wrap 2->0 correctly and every frame reads back intact.
6. Assert rd_en and rd_release with full_count=0, then pulse rst_n low mid-frame (wa=17) -> the requests are ignored (rd_data_valid=0) and all state returns to reset values asynchronously. The next frame starts at bank 0, address 0.
